queue_reader: RTL and testbench

QUEUE_READER -- requirements
Module: queue_reader

---
 rtl/queue_pkg.sv | 6 +
 rtl/queue_skid_buf.sv | 51 +++++
 rtl/queue_reader.sv | 58 +++++
 tb/tb_queue_reader.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/queue_pkg.sv
// Shared constants for the queue reader: data width default and skid-buffer depth.
package queue_pkg;
    localparam int QR_DATA_W = 8;
    localparam int BUF_DEPTH = 2;
    localparam int CNT_W     = 16;
endpackage

// File: rtl/queue_skid_buf.sv
// Two-entry in-order buffer between the upstream pop response and the downstream handshake.
module queue_skid_buf
    import queue_pkg::*;
#(
    parameter int DATA_W = QR_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] head_o,
    output logic [1:0]        occ_o
);
    logic [DATA_W-1:0] ent_q [BUF_DEPTH];
    logic [DATA_W-1:0] ent_d [BUF_DEPTH];
    logic [1:0]        occ_q, occ_d;
    logic [1:0]        wr_idx;

    // Entry 0 is always the head; a pop shifts entry 1 down, a push lands after the survivors.
    assign wr_idx = occ_q - {1'b0, pop_i};

    always_comb begin
        ent_d = ent_q;
        occ_d = occ_q;
        if (flush_i) begin
            occ_d = 2'd0;
        end else begin
            if (pop_i) ent_d[0] = ent_q[1];
            if (push_i) ent_d[wr_idx[0]] = push_data_i;
            occ_d = occ_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= 2'd0;
            for (int i = 0; i < BUF_DEPTH; i++) ent_q[i] <= '0;
        end else begin
            occ_q <= occ_d;
            ent_q <= ent_d;
        end
    end

    assign head_o = (occ_q != 2'd0) ? ent_q[0] : '0;
    assign occ_o  = occ_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_i && !pop_i && !flush_i && occ_q == 2'(BUF_DEPTH)));
endmodule

// File: rtl/queue_reader.sv
// Pops an upstream queue with one-cycle read latency and presents words on a valid/ready port.
module queue_reader
    import queue_pkg::*;
#(
    parameter int DATA_W = QR_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              flush,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  rd_count
);
    logic             rd_pending_q;
    logic             armed_q;
    logic [CNT_W-1:0] rd_count_q, rd_count_d;
    logic [1:0]       occ;
    logic [2:0]       level;
    logic             pop, push;

    assign pop   = out_valid & out_ready & ~flush;
    assign push  = rd_pending_q & ~flush;
    assign level = 3'(occ) + 3'(rd_pending_q) - 3'(pop);

    // armed_q keeps fifo_rd low until the first edge after reset release.
    assign fifo_rd    = armed_q & ~fifo_empty & ~flush & (level < 3'(BUF_DEPTH));
    assign rd_count_d = rd_count_q + CNT_W'(pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_q      <= 1'b0;
            rd_pending_q <= 1'b0;
            rd_count_q   <= '0;
        end else begin
            armed_q      <= 1'b1;
            rd_pending_q <= fifo_rd;
            rd_count_q   <= rd_count_d;
        end
    end

    queue_skid_buf #(.DATA_W(DATA_W)) u_buf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (fifo_data),
        .pop_i       (pop),
        .flush_i     (flush),
        .head_o      (out_data),
        .occ_o       (occ)
    );

    assign out_valid = (occ != 2'd0);
    assign rd_count  = rd_count_q;
endmodule

// File: tb/tb_queue_reader.sv
// Self-checking bench for queue_reader: directed tables, hand sequences and a random run
// checked by a scoreboard of words popped upstream and not yet delivered or discarded.
module tb_queue_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty, fifo_rd;
    logic [7:0]  fifo_data = 8'h00;
    logic        flush = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] rd_count;

    logic [7:0]  up_mem [256];
    logic [31:0] up_wr = 0;
    logic [31:0] up_rd = 0;

    int total = 0;
    int bad   = 0;

    logic [7:0]  exp_q [$];
    int          exp_t [$];
    logic [15:0] mdl_cnt = 16'd0;
    int          cyc = 0;

    typedef struct {
        logic        rdy;
        logic        fl;
        logic        e_rd;
        logic        e_ov;
        logic [7:0]  e_od;
        logic [15:0] e_cnt;
    } vec_t;
    vec_t tv [$];

    queue_reader dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .fifo_data  (fifo_data),
        .flush      (flush),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .rd_count   (rd_count)
    );

    always #5 clk = ~clk;

    // Upstream queue: registered read data, one cycle after the pop request.
    assign fifo_empty = (up_wr == up_rd);
    always @(posedge clk) begin
        if (fifo_rd) begin
            fifo_data <= up_mem[up_rd[7:0]];
            up_rd     <= up_rd + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        up_mem[up_wr[7:0]] = w;
        up_wr = up_wr + 1;
    endtask

    task automatic monitor();
        logic       p_ov = 1'b0, p_rdy = 1'b0, p_fl = 1'b0, p_rst = 1'b1;
        logic [7:0] p_od = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("sb_count", 32'(rd_count), 32'(mdl_cnt));
                if (out_valid) begin
                    if (exp_q.size() == 0) chk("sb_spurious_valid", 32'(out_valid), 32'd0);
                    else chk("sb_head", 32'(out_data), 32'(exp_q[0]));
                end else begin
                    chk("sb_idle_data", 32'(out_data), 32'd0);
                    if (exp_q.size() > 0 && cyc - exp_t[0] >= 2)
                        chk("sb_latency", 32'(out_valid), 32'd1);
                end
                if (fifo_rd) chk("sb_rd_when_empty", 32'(fifo_empty), 32'd0);
                if (p_ov && !p_rdy && !p_fl && !p_rst) begin
                    chk("sb_hold_valid", 32'(out_valid), 32'd1);
                    chk("sb_hold_data", 32'(out_data), 32'(p_od));
                end
            end
            if (rst || flush) begin
                exp_q.delete();
                exp_t.delete();
                if (rst) mdl_cnt = 16'd0;
            end else begin
                if (out_valid && out_ready && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    void'(exp_t.pop_front());
                    mdl_cnt = mdl_cnt + 16'd1;
                end
                if (fifo_rd) begin
                    exp_q.push_back(up_mem[up_rd[7:0]]);
                    exp_t.push_back(cyc);
                end
            end
            p_ov = out_valid; p_rdy = out_ready; p_fl = flush; p_rst = rst; p_od = out_data;
            cyc++;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_tab(input string nm);
        foreach (tv[i]) begin
            out_ready = tv[i].rdy;
            flush     = tv[i].fl;
            @(negedge clk);
            chk($sformatf("%s[%0d].fifo_rd", nm, i), 32'(fifo_rd), 32'(tv[i].e_rd));
            chk($sformatf("%s[%0d].out_valid", nm, i), 32'(out_valid), 32'(tv[i].e_ov));
            chk($sformatf("%s[%0d].out_data", nm, i), 32'(out_data), 32'(tv[i].e_od));
            chk($sformatf("%s[%0d].rd_count", nm, i), 32'(rd_count), 32'(tv[i].e_cnt));
            @(posedge clk); #1;
        end
        flush = 1'b0;
        tv.delete();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        flush = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (up_wr == up_rd) break;
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", 32'(fifo_empty), 32'd1);
        chk("drain_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] nxt;
        int n;
        fork monitor(); join_none

        // reset state
        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_rd", 32'(fifo_rd), 32'd0);
        chk("rst_count", 32'(rd_count), 32'd0);

        // basic read of one word
        do_reset();
        push_word(8'hA5);
        tv.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 16'd0});
        tv.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0});
        tv.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 16'd0});
        tv.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd1});
        run_tab("basic");

        // backpressure: 5 words queued, ready held low then raised
        do_reset();
        for (int i = 0; i < 5; i++) push_word(8'(i));
        tv.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 16'd0});
        tv.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 16'd0});
        for (int i = 0; i < 4; i++) tv.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'd0});
        tv.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 16'd0});
        tv.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 16'd1});
        tv.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 16'd2});
        tv.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 16'd3});
        tv.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 8'h04, 16'd4});
        tv.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd5});
        run_tab("bp");

        // streaming: 10 words on 10 consecutive cycles
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) push_word(8'(i));
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk("stream_start", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("stream_valid[%0d]", i), 32'(out_valid), 32'd1);
            chk($sformatf("stream_data[%0d]", i), 32'(out_data), 32'(i));
            @(negedge clk);
        end
        chk("stream_count", 32'(rd_count), 32'd10);
        chk("stream_end", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // flush with one word buffered and one in flight
        do_reset();
        for (int i = 0; i < 5; i++) push_word(8'(i));
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_rd", 32'(fifo_rd), 32'd0);
        chk("flush_valid_before", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("flush_valid_after", 32'(out_valid), 32'd0);
        chk("flush_count", 32'(rd_count), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 20 && n < 3; k++) begin
            @(negedge clk);
            if (out_valid) begin
                chk($sformatf("flush_resume[%0d]", n), 32'(out_data), 32'(n + 2));
                n++;
            end
        end
        chk("flush_resume_n", 32'(n), 32'd3);
        @(posedge clk); #1;
        @(negedge clk);
        chk("flush_count_end", 32'(rd_count), 32'd3);
        @(posedge clk); #1;

        // reset asserted between edges in the middle of a stream
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) push_word(8'(8'h40 + i));
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_data", 32'(out_data), 32'd0);
        chk("midrst_rd", 32'(fifo_rd), 32'd0);
        chk("midrst_count", 32'(rd_count), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midrst_no_early_rd", 32'(fifo_rd), 32'd0);
        nxt = up_mem[up_rd[7:0]];
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk("midrst_first_valid", 32'(out_valid), 32'd1);
        chk("midrst_first_data", 32'(out_data), 32'(nxt));
        chk("midrst_count_after", 32'(rd_count), 32'd0);
        @(posedge clk); #1;
        drain();

        // random traffic, stalls and occasional flushes
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            if (up_wr - up_rd < 6 && $urandom_range(0, 2) != 0) push_word(8'($urandom));
        end
        drain();

        // rd_count wrap after 65536 pops
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 70000; k++) begin
            @(posedge clk); #1;
            if (up_wr - up_rd < 4) push_word(8'(k));
            if (mdl_cnt == 16'hFFFF) break;
        end
        @(negedge clk);
        chk("wrap_ffff", 32'(rd_count), 32'h0000FFFF);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (up_wr - up_rd < 4) push_word(8'(k));
            if (mdl_cnt == 16'h0000) break;
        end
        @(negedge clk);
        chk("wrap_zero", 32'(rd_count), 32'd0);
        @(posedge clk); #1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
